// File: rtl/nios_pio_in_capture.sv
// Avalon-MM input PIO: per-pin 2-flop sync and debounce, sticky edge capture,
// and a maskable level interrupt. Four word registers: data, reserved, mask, capture.

module nios_pio_in_bit #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_TYPE       = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic deb,
    output logic evt
);
    logic s1, s2, deb_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            deb_d <= 1'b0;
        end else begin
            s1    <= pin;
            s2    <= s1;
            deb_d <= deb;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
            always_ff @(posedge clk) begin
                if (reset) deb <= 1'b0;
                else       deb <= s2;
            end
        end else begin : g_deb
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
            logic [CW-1:0] cnt;

            // cnt counts mismatch cycles already seen; the flip happens on the
            // DEBOUNCE_CYCLES-th consecutive one, so any agreement restarts it.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt <= '0;
                    deb <= 1'b0;
                end else if (s2 == deb) begin
                    cnt <= '0;
                end else if (cnt >= LAST) begin
                    cnt <= '0;
                    deb <= s2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    endgenerate

    always_comb begin
        case (EDGE_TYPE)
            0:       evt = deb & ~deb_d;
            1:       evt = ~deb & deb_d;
            default: evt = deb ^ deb_d;
        endcase
    end
endmodule

module nios_pio_in_capture #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] deb, evt, edge_capture, irq_mask;
    logic [31:0]      rd_next;
    logic             wr;

    assign wr = chipselect && !write_n;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            nios_pio_in_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .EDGE_TYPE      (EDGE_TYPE)
            ) u_bit (
                .clk  (clk),
                .reset(reset),
                .pin  (in_port[i]),
                .deb  (deb[i]),
                .evt  (evt[i])
            );
        end
        if (WIDTH < 32) begin : g_unused
            logic unused_wd;
            assign unused_wd = ^writedata[31:WIDTH];
        end
    endgenerate

    // A new event wins over a same-cycle W1C on its own bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_capture <= '0;
            irq_mask     <= '0;
            irq          <= 1'b0;
        end else begin
            if (wr && address == 2'd3)
                edge_capture <= (edge_capture & ~writedata[WIDTH-1:0]) | evt;
            else
                edge_capture <= edge_capture | evt;
            if (wr && address == 2'd2)
                irq_mask <= writedata[WIDTH-1:0];
            irq <= |(edge_capture & irq_mask);
        end
    end

    always_comb begin
        rd_next = '0;
        case (address)
            2'd0:    rd_next[WIDTH-1:0] = deb;
            2'd2:    rd_next[WIDTH-1:0] = irq_mask;
            2'd3:    rd_next[WIDTH-1:0] = edge_capture;
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) readdata <= '0;
        else       readdata <= rd_next;
    end
endmodule
